// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the instruction/data memory bus arbiter.
package mem_arb_pkg;

  localparam int DEF_ADDR_W = 64;
  localparam int DEF_DATA_W = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter (instruction fetch, data) onto a single memory port with
// one outstanding transaction, round-robin tie break and fetch-abort support.
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                ib_req,
  input  logic [ADDR_W-1:0]   ib_addr,
  output logic                ib_ready,
  input  logic                ib_abort,
  output logic                ib_rvalid,
  output logic [DATA_W-1:0]   ib_rdata,
  input  logic                db_req,
  input  logic                db_we,
  input  logic [ADDR_W-1:0]   db_addr,
  input  logic [DATA_W-1:0]   db_wdata,
  input  logic [DATA_W/8-1:0] db_wstrb,
  output logic                db_ready,
  output logic                db_rvalid,
  output logic [DATA_W-1:0]   db_rdata,
  output logic                m_req,
  output logic                m_we,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  input  logic                m_ready,
  input  logic                m_rvalid,
  input  logic [DATA_W-1:0]   m_rdata
);

  localparam int STRB_W = DATA_W / 8;

  state_t              state_reg;
  owner_t              owner_reg;
  owner_t              last_grant_reg;
  logic                drop_reg;
  logic                m_req_reg;
  logic                m_we_reg;
  logic [ADDR_W-1:0]   m_addr_reg;
  logic [DATA_W-1:0]   m_wdata_reg;
  logic [STRB_W-1:0]   m_wstrb_reg;
  logic                ib_rvalid_reg;
  logic                db_rvalid_reg;
  logic [DATA_W-1:0]   rdata_reg;

  logic grant_inst;
  logic grant_data;
  logic inst_pending;
  logic drop_now;

  // Acceptance must pulse in the same cycle the request is seen idle, so the
  // grant decode is combinational; everything else is registered.
  always_comb begin
    grant_inst = 1'b0;
    grant_data = 1'b0;
    if (!reset && state_reg == IDLE) begin
      if (ib_req && db_req) begin
        grant_data = (last_grant_reg == OWN_INST);
        grant_inst = (last_grant_reg == OWN_DATA);
      end else begin
        grant_inst = ib_req;
        grant_data = db_req;
      end
    end
  end

  assign inst_pending = (state_reg != IDLE) && (owner_reg == OWN_INST);
  assign drop_now     = drop_reg || (ib_abort && inst_pending);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg      <= IDLE;
      owner_reg      <= OWN_INST;
      last_grant_reg <= OWN_INST;
      drop_reg       <= 1'b0;
      m_req_reg      <= 1'b0;
      m_we_reg       <= 1'b0;
      m_addr_reg     <= '0;
      m_wdata_reg    <= '0;
      m_wstrb_reg    <= '0;
      ib_rvalid_reg  <= 1'b0;
      db_rvalid_reg  <= 1'b0;
      rdata_reg      <= '0;
    end else begin
      ib_rvalid_reg <= 1'b0;
      db_rvalid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (grant_inst || grant_data) begin
            owner_reg      <= grant_inst ? OWN_INST : OWN_DATA;
            last_grant_reg <= grant_inst ? OWN_INST : OWN_DATA;
            m_addr_reg     <= grant_inst ? ib_addr : db_addr;
            m_we_reg       <= grant_data && db_we;
            m_wdata_reg    <= grant_inst ? '0 : db_wdata;
            m_wstrb_reg    <= grant_inst ? '0 : db_wstrb;
            m_req_reg      <= 1'b1;
            drop_reg       <= grant_inst && ib_abort;
            state_reg      <= ISSUE;
          end
        end
        ISSUE: begin
          drop_reg <= drop_now;
          if (m_ready) begin
            m_req_reg <= 1'b0;
            state_reg <= WAIT;
          end
        end
        WAIT: begin
          drop_reg <= drop_now;
          if (m_rvalid) begin
            // An abort arriving alongside the response still suppresses it.
            rdata_reg     <= m_rdata;
            ib_rvalid_reg <= (owner_reg == OWN_INST) && !drop_now;
            db_rvalid_reg <= (owner_reg == OWN_DATA);
            drop_reg      <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign ib_ready  = grant_inst;
  assign db_ready  = grant_data;
  assign ib_rvalid = ib_rvalid_reg;
  assign db_rvalid = db_rvalid_reg;
  assign ib_rdata  = rdata_reg;
  assign db_rdata  = rdata_reg;
  assign m_req     = m_req_reg;
  assign m_we      = m_we_reg;
  assign m_addr    = m_addr_reg;
  assign m_wdata   = m_wdata_reg;
  assign m_wstrb   = m_wstrb_reg;

endmodule
